// File: rtl/divider_bank_pkg.sv
// Shared types and constants for the divider bank.
// Channel FSM states and mode encodings.
package divider_bank_pkg;

    typedef enum logic {
        DIVCH_IDLE,
        DIVCH_RUN
    } divch_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/divider_channel.sv
// One programmable tick channel.
// Holds the IDLE/RUN FSM, the counter and the tick flop.
module divider_channel
    import divider_bank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ch_en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    divch_state_t     state;
    divch_state_t     state_d;
    logic [WIDTH-1:0] count_d;
    logic             tick_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DIVCH_IDLE;
            count <= '0;
            tick  <= 1'b0;
        end else begin
            state <= state_d;
            count <= count_d;
            tick  <= tick_d;
        end
    end

    always_comb begin
        state_d = state;
        count_d = count;
        tick_d  = 1'b0;
        unique case (state)
            DIVCH_IDLE: begin
                if (load || (mode == MODE_PERIODIC && ch_en && en)) begin
                    state_d = DIVCH_RUN;
                    count_d = '0;
                end
            end
            DIVCH_RUN: begin
                // Load beats a coincident terminal event and ignores enables.
                if (load) begin
                    count_d = '0;
                end else if (en && ch_en) begin
                    if (count >= period) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        if (mode == MODE_ONESHOT)
                            state_d = DIVCH_IDLE;
                    end else begin
                        count_d = count + WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = DIVCH_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign busy = (state == DIVCH_RUN);

endmodule

// File: rtl/divider_bank.sv
// Multi-channel programmable tick generator.
// NCH independent divider_channel instances sharing one clock.
module divider_bank
    import divider_bank_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NCH-1:0]            ch_en,
    input  logic [NCH-1:0]            mode,
    input  logic [NCH-1:0]            load,
    input  logic [NCH-1:0][WIDTH-1:0] period,
    output logic [NCH-1:0]            tick,
    output logic [NCH-1:0]            busy,
    output logic [NCH-1:0][WIDTH-1:0] count
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        divider_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .ch_en (ch_en[i]),
            .mode  (mode[i]),
            .load  (load[i]),
            .period(period[i]),
            .tick  (tick[i]),
            .busy  (busy[i]),
            .count (count[i])
        );
    end

endmodule

// File: doc/divider_bank.md
# divider_bank

Multi-channel programmable tick generator; successor to the single-channel fixed-mode counter divider. Provides NCH independent counters, each with a run-time period, a periodic or one-shot mode, a per-channel pause, and a phase-restart (load). Sits beside the VGA timing and game-logic blocks. It supplies snake step ticks, input debounce sampling strobes and one-shot timeouts from the single system clock.

## Interface
- NCH, 4: number of channels (1..16)
- WIDTH, 16: counter and period width in bits
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; clears every channel
- en  in  1  global enable; low freezes all counters and states (load still honoured)
- ch_en  in  NCH  per-channel run enable; low pauses that channel
- mode  in  NCH  per channel: 0 = periodic, 1 = one-shot
- load  in  NCH  per-channel restart pulse
- period  in  NCH x WIDTH (packed, channel i at [i])  terminal count; tick spacing = period+1 active cycles
- tick  out  NCH  registered one-cycle pulse at each terminal event
- busy  out  NCH  channel in RUN state
- count  out  NCH x WIDTH  current counter value (debug/phase readback)

## Operation
- Per-channel FSM, states IDLE and RUN. After reset: IDLE, count=0, tick=0, busy=0. Tick is never asserted by reset.
- Active edge for a channel in RUN: en=1 and ch_en[i]=1. At a non-active edge, count and state hold and tick<=0.
- IDLE -> RUN at any edge where load[i]=1, or where mode[i]=0 with ch_en[i]=1 and en=1. Entry edge: count<=0, tick<=0.
- RUN, active edge, count >= period[i] (terminal event): count<=0, tick<=1.
  - If mode[i]=1: RUN -> IDLE on the same edge.
  - If mode[i]=0: stay in RUN.
- RUN, active edge, count < period[i]: count<=count+1, tick<=0.
- The terminal compare is >=. A period lowered below the current count causes a terminal event on the next active edge, with no wrap through 2^WIDTH.
- period=0: tick on every active edge (tick held high continuously in periodic mode).
- load[i]=1 in RUN: count<=0, tick<=0, state RUN. Load has priority over a coincident terminal event (no tick) and acts even when en=0 or ch_en[i]=0.
- A mode change takes effect at the next evaluation:
  - Periodic to one-shot while running: ends at the next terminal event.
  - One-shot to periodic in IDLE with ch_en=1: starts as a normal entry.
- One-shot in IDLE: count stays 0. busy=0 and tick=0 until the next load.
- reset overrides load, en and everything else in the same cycle.
- Channels are fully independent. Asserting several load bits in one cycle phase-aligns those channels exactly.

## Timing
- Latency: tick rises on the edge after the edge at which count equals period, i.e. P+1 active edges after the RUN-entry edge.
- Periodic: tick pulses every P+1 active edges. Pauses (en or ch_en low) stretch the interval by the number of paused cycles.
- busy reflects state after the edge. In one-shot mode, busy falls on the same edge that tick rises.
- Reset: all outputs 0 at the first edge with reset=1, and held while reset stays high.
- No combinational path from any input to tick, busy or count. All outputs are flop outputs.

## Structure
- Package divider_bank_pkg holds:
  - enum typedef divch_state_t {DIVCH_IDLE, DIVCH_RUN}
  - constants MODE_PERIODIC=1'b0 and MODE_ONESHOT=1'b1
- Sub-module divider_channel (parameter WIDTH) holds one FSM, counter and tick flop. divider_bank instantiates NCH of these in a generate loop and packs and unpacks the vectors.

## Test plan
- Reset then periodic channel 0, period=3, ch_en=1, en=1 -> tick[0] high one cycle every 4 cycles, first tick 4 edges after entry; count cycles 0,1,2,3.
- One-shot channel 1, period=5, load pulse -> busy high for 6 edges; a single tick on the 6th edge with busy falling on the same edge; no further ticks until the next load.
- Periodic period=9, drop period to 2 when count=7 -> terminal event on the next active edge, count 0, then tick spacing 3 cycles.
- Load coincident with a terminal event (period=4, load when count=4) -> no tick, count=0, next tick 5 edges later.
- ch_en low for 3 cycles mid-count, and separately en low -> count and state freeze; tick spacing grows by exactly 3; load during en=0 still zeroes count.
- Channels 0..3 free-running at periods 1,2,3,4, then load=4'b1111 -> all counts 0 on the same edge; reset mid-run -> all tick, busy and count 0 next edge.
